// File: rtl/config_addr_editor.sv
// Hex address editor: up/down edits the selected nibble, left/right moves
// the selection, load overwrites, and a held up/down auto-repeats.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   button_left  level, high = pressed; selection toward MSB
//   button_right level, high = pressed; selection toward LSB
//   button_up    level, high = pressed; selected nibble +1 mod 16
//   button_down  level, high = pressed; selected nibble -1 mod 16
//   load         replace value with load_value
//   load_value   value to load
//   value        edited address (registered)
//   current_seg  one-hot selected nibble, bit 0 = LSB nibble
//   changed      one-cycle pulse after each value write
module config_addr_editor #(
  parameter int unsigned NIBBLES = 2,
  parameter logic [4*NIBBLES-1:0] RESET_VALUE = '0,
  parameter int unsigned HOLD_CYCLES = 500,
  parameter int unsigned REPEAT_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 button_left,
  input  logic                 button_right,
  input  logic                 button_up,
  input  logic                 button_down,
  input  logic                 load,
  input  logic [4*NIBBLES-1:0] load_value,
  output logic [4*NIBBLES-1:0] value,
  output logic [NIBBLES-1:0]   current_seg,
  output logic                 changed
);

  localparam int unsigned W = 4 * NIBBLES;
  localparam int unsigned CMAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ?
    HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW =
    (CMAX < 1) ? 1 : $clog2(CMAX + 1);

  // Counter restarts at the step edge, so a step is due when the
  // count reaches the period minus one.
  localparam logic [CW-1:0] HOLD_TH =
    CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CW-1:0] REP_TH =
    CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT = CW'(CMAX);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic trk_dn_q, trk_dn_d;
  logic [W-1:0] value_q, value_d;
  logic [NIBBLES-1:0] seg_q, seg_d;
  logic changed_q, changed_d;

  // {left, right, up, down}
  logic [3:0] prev_q;
  logic [3:0] btn;
  logic [3:0] ev;

  logic [W-1:0] inc_v;
  logic [W-1:0] dec_v;
  logic [NIBBLES-1:0] rot_l;
  logic [NIBBLES-1:0] rot_r;
  logic tracked_hi;
  logic step_due;

  assign btn = {button_left, button_right,
                button_up, button_down};
  assign ev = btn & ~prev_q;

  assign tracked_hi = trk_dn_q ? button_down
                               : button_up;

  // Per-nibble arithmetic: only the selected
  // nibble moves, no carry or borrow.
  always_comb begin
    inc_v = value_q;
    dec_v = value_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (seg_q[i]) begin
        inc_v[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
        dec_v[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
      end
    end
  end

  // Rotations wrap; with one nibble they are
  // the identity.
  always_comb begin
    rot_l = '0;
    rot_r = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      rot_l[(i + 1) % NIBBLES] = seg_q[i];
      rot_r[i] = seg_q[(i + 1) % NIBBLES];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    trk_dn_d  = trk_dn_q;
    value_d   = value_q;
    seg_d     = seg_q;
    changed_d = 1'b0;
    step_due  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!tracked_hi) begin
          state_d = IDLE;
        end else if (cnt_q >= HOLD_TH) begin
          step_due = 1'b1;
          state_d  = REPEAT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!tracked_hi) begin
          state_d = IDLE;
        end else if (cnt_q >= REP_TH) begin
          step_due = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // One action per cycle, highest first.
    if (load) begin
      value_d   = load_value;
      changed_d = 1'b1;
      state_d   = IDLE;
      cnt_d     = '0;
    end else if (ev[1]) begin
      value_d   = inc_v;
      changed_d = 1'b1;
      state_d   = HOLD;
      trk_dn_d  = 1'b0;
      cnt_d     = '0;
    end else if (ev[0]) begin
      value_d   = dec_v;
      changed_d = 1'b1;
      state_d   = HOLD;
      trk_dn_d  = 1'b1;
      cnt_d     = '0;
    end else if (step_due) begin
      value_d   = trk_dn_q ? dec_v : inc_v;
      changed_d = 1'b1;
    end else if (ev[3]) begin
      seg_d = rot_l;
    end else if (ev[2]) begin
      seg_d = rot_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      trk_dn_q  <= 1'b0;
      value_q   <= RESET_VALUE;
      seg_q     <= NIBBLES'(1);
      changed_q <= 1'b0;
      // Buttons held through reset must be
      // released before they count.
      prev_q    <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trk_dn_q  <= trk_dn_d;
      value_q   <= value_d;
      seg_q     <= seg_d;
      changed_q <= changed_d;
      prev_q    <= btn;
    end
  end

  assign value       = value_q;
  assign current_seg = seg_q;
  assign changed     = changed_q;

endmodule

// File: tb/tb_config_addr_editor.sv
// Scoreboard bench for config_addr_editor.
// Driver models each edge; monitor compares.
module tb_config_addr_editor;

  localparam int N  = 2;
  localparam int HC = 4;
  localparam int RC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       bl, br, bu, bd;
  logic       ld;
  logic [7:0] lv;
  logic [7:0] value;
  logic [1:0] seg;
  logic       changed;

  config_addr_editor #(
    .NIBBLES(N),
    .RESET_VALUE(8'h00),
    .HOLD_CYCLES(HC),
    .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_left(bl),
    .button_right(br),
    .button_up(bu),
    .button_down(bd),
    .load(ld),
    .load_value(lv),
    .value(value),
    .current_seg(seg),
    .changed(changed)
  );

  typedef struct packed {
    logic [7:0] v;
    logic [1:0] s;
    logic       c;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int tests = 0;
  int fails = 0;

  // Reference model: nibble index, phase
  // (0 none, 1 hold, 2 repeat), edges since
  // last step.
  logic [7:0] m_v;
  int         m_seg;
  bit         m_ch;
  int         m_phase;
  int         m_since;
  bit         m_trk;
  bit   [3:0] m_prev;

  task automatic bump(bit dn);
    logic [3:0] n;
    n = m_v[4*m_seg +: 4];
    n = dn ? n - 4'd1 : n + 4'd1;
    m_v[4*m_seg +: 4] = n;
    m_ch = 1'b1;
  endtask

  task automatic drive(bit r, bit l, bit rt,
                       bit u, bit d, bit lo,
                       logic [7:0] lval);
    bit [3:0] b;
    bit [3:0] ev;
    bit due;
    bit held;
    int sn;
    exp_t x;
    reset = r; bl = l; br = rt;
    bu = u; bd = d; ld = lo; lv = lval;
    b  = {l, rt, u, d};
    ev = b & ~m_prev;
    due = 1'b0;
    if (r) begin
      m_v = 8'h00; m_seg = 0; m_ch = 1'b0;
      m_phase = 0; m_since = 0; m_trk = 1'b0;
      m_prev = 4'hF;
    end else begin
      m_ch = 1'b0;
      if (m_phase != 0) begin
        held = m_trk ? d : u;
        sn = m_since + 1;
        if (!held) m_phase = 0;
        else if (sn >= ((m_phase == 1) ? HC : RC))
          due = 1'b1;
        else m_since = sn;
      end
      if (lo) begin
        m_v = lval; m_ch = 1'b1; m_phase = 0;
      end else if (ev[1]) begin
        bump(1'b0);
        m_phase = 1; m_trk = 1'b0; m_since = 0;
      end else if (ev[0]) begin
        bump(1'b1);
        m_phase = 1; m_trk = 1'b1; m_since = 0;
      end else if (due) begin
        bump(m_trk);
        m_phase = 2; m_since = 0;
      end else if (ev[3]) begin
        m_seg = (m_seg + 1) % N;
      end else if (ev[2]) begin
        m_seg = (m_seg + N - 1) % N;
      end
      m_prev = b;
    end
    x.v = m_v;
    x.s = 2'(1 << m_seg);
    x.c = m_ch;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      tests = tests + 3;
      if (value !== e.v) begin
        fails = fails + 1;
        $display("FAIL value: got %h exp %h t=%0t",
                 value, e.v, $time);
      end
      if (seg !== e.s) begin
        fails = fails + 1;
        $display("FAIL seg: got %b exp %b t=%0t",
                 seg, e.s, $time);
      end
      if (changed !== e.c) begin
        fails = fails + 1;
        $display("FAIL changed: got %b exp %b t=%0t",
                 changed, e.c, $time);
      end
    end
  end

  bit rl, rr, ru, rd;

  initial begin
    reset = 1'b1; bl = 0; br = 0;
    bu = 0; bd = 0; ld = 0; lv = 8'h00;

    for (int i = 0; i < 10; i++)
      drive(1, 0, 0, 0, 0, 0, 8'h00);
    idle(2);

    // up once, down twice: 01, 00, 0F
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 1, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 1, 0, 8'h00);
    idle(2);

    // left, left, right
    drive(0, 1, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 1, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 0, 0, 8'h00);
    idle(1);

    // back to seg 0, clear, hold up 12
    drive(0, 0, 1, 0, 0, 1, 8'h00);
    drive(0, 0, 1, 0, 0, 0, 8'h00);
    idle(2);
    drive(0, 0, 1, 0, 0, 0, 8'h00);
    idle(1);
    for (int i = 0; i < 12; i++)
      drive(0, 0, 0, 1, 0, 0, 8'h00);
    idle(6);

    // up+left together, then load+up
    drive(0, 1, 0, 1, 0, 0, 8'h00);
    idle(1);
    drive(0, 0, 0, 1, 0, 1, 8'hA5);
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    idle(6);

    // reset mid-repeat with up held
    for (int i = 0; i < 9; i++)
      drive(0, 0, 0, 1, 0, 0, 8'h00);
    drive(1, 0, 0, 1, 0, 0, 8'h00);
    drive(1, 0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++)
      drive(0, 0, 0, 1, 0, 0, 8'h00);
    idle(2);
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    idle(3);

    rl = 0; rr = 0; ru = 0; rd = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rl = ~rl;
      if ($urandom_range(0, 5) == 0) rr = ~rr;
      if ($urandom_range(0, 11) == 0) ru = ~ru;
      if ($urandom_range(0, 11) == 0) rd = ~rd;
      drive(($urandom_range(0, 299) == 0),
            rl, rr, ru, rd,
            ($urandom_range(0, 49) == 0),
            8'($urandom));
    end
    idle(2);

    @(negedge clk);
    #1;
    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: %0d left, exp 0",
               q.size());
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/config_addr_editor.md
CONFIG_ADDR_EDITOR -- requirements
Module: config_addr_editor

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 2, giving the number of hex digits edited (1..8).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, giving the value loaded at reset (width 4*NIBBLES).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 500, giving the cycles a held up/down button waits before auto-repeat starts.
REQ-004 The block SHALL have parameter REPEAT_CYCLES, default 100, giving the cycles between auto-repeat steps.
REQ-005 The block SHALL have the following ports, one per line:
  clk  input  1  single clock; all logic on rising edge
  reset  input  1  synchronous, active-high reset
  button_left  input  1  debounced level; high = pressed
  button_right  input  1  debounced level; high = pressed
  button_up  input  1  debounced level; high = pressed
  button_down  input  1  debounced level; high = pressed
  load  input  1  high = replace value with load_value
  load_value  input  4*NIBBLES  value to load
  value  output  4*NIBBLES  edited address, registered
  current_seg  output  NIBBLES  one-hot selected digit; bit 0 = least-significant nibble
  changed  output  1  one-cycle pulse after any value write

Function
REQ-006 Each button SHALL have a previous-sample register; a press event SHALL be button high while its previous sample is low.
REQ-007 At most one action SHALL be applied per cycle, with priority load > up > down > left > right; lower-priority events in that cycle SHALL be discarded.
REQ-008 An action SHALL take effect on the same rising edge that samples the event; outputs SHALL show the result in the next cycle (latency 1).
REQ-009 Up SHALL increment only the selected nibble modulo 16, with no carry into adjacent nibbles (F->0).
REQ-010 Down SHALL decrement only the selected nibble modulo 16, with no borrow (0->F).
REQ-011 Left SHALL move the selection one nibble toward the MSB, wrapping from NIBBLES-1 to 0.
REQ-012 Right SHALL move the selection one nibble toward the LSB, wrapping from 0 to NIBBLES-1.
REQ-013 With NIBBLES=1, left and right SHALL leave current_seg unchanged.
REQ-014 Load SHALL write load_value to value in one cycle and SHALL leave current_seg unchanged.
REQ-015 Load SHALL cancel any auto-repeat and return the FSM to IDLE.
REQ-016 The auto-repeat FSM SHALL have states IDLE, HOLD and REPEAT, and SHALL track the up or down button that started it.
REQ-017 IDLE->HOLD SHALL occur on an applied up/down event, clearing the counter.
REQ-018 In HOLD, after HOLD_CYCLES cycles from the initial step with the button still high, the FSM SHALL apply one step and enter REPEAT.
REQ-019 In REPEAT, the FSM SHALL apply one step every REPEAT_CYCLES cycles while the button stays high.
REQ-020 Release of the tracked button in HOLD or REPEAT SHALL return the FSM to IDLE with no further step.
REQ-021 A new applied up/down event during HOLD/REPEAT SHALL restart HOLD tracking the new button.
REQ-022 Left/right events SHALL be applied during HOLD/REPEAT without disturbing the FSM; a repeat step in that cycle SHALL take priority and the left/right event SHALL be discarded.
REQ-023 changed SHALL pulse high for exactly one cycle after each up, down, repeat or load write, even if the written value equals the old value.
REQ-024 The counter SHALL be wide enough for max(HOLD_CYCLES, REPEAT_CYCLES) and SHALL saturate (never wrap) in IDLE.

Reset
REQ-025 On reset, value SHALL become RESET_VALUE, current_seg SHALL become one-hot bit 0, changed SHALL become 0, the FSM SHALL enter IDLE and the counter SHALL become 0.
REQ-026 On reset, all previous-sample registers SHALL be set to 1, so a button held through reset is not a press until released and re-pressed.
REQ-027 Reset SHALL override load and all button events in the same cycle.

Verification (NIBBLES=2, RESET_VALUE=0, HOLD_CYCLES=4, REPEAT_CYCLES=2)
REQ-028 Reset 10 cycles -> value=0x00, current_seg=2'b01, changed=0.
REQ-029 Up for 1 cycle, then down twice -> value 0x01, then 0x00, then 0x0F; value 0xF0 never appears; changed pulses 3 times.
REQ-030 Left, left, right -> current_seg 2'b10, 2'b01, 2'b10.
REQ-031 Up held 12 cycles from edge T on seg 0 -> steps at T, T+4, T+6, T+8, T+10; value=0x05; no step after release.
REQ-032 Up+left in the same cycle -> value +1, current_seg unchanged; load=1 with load_value=0xA5 plus up -> value 0xA5, FSM IDLE.
REQ-033 Reset asserted mid-REPEAT with up held, then released -> value 0x00, no steps until up is released and re-pressed.
